// File: rtl/vga_scale_dis_if.sv
// Video-memory read port between vga_scale_dis (master) and the framebuffer RAM (slave).
// The RAM returns vga_data one pclk after vmem_r_addr.
interface vga_scale_dis_if #(
  parameter int VMEM_ADDR_WIDTH = 20
);
  logic [VMEM_ADDR_WIDTH-1:0] vmem_r_addr;
  logic                       vmem_r_en;
  logic [11:0]                vga_data;

  modport master (output vmem_r_addr, output vmem_r_en, input vga_data);
  modport slave  (input vmem_r_addr, input vmem_r_en, output vga_data);
endinterface

// File: rtl/vga_scale_dis.sv
// VGA timing generator with SxS integer pixel scaling (S = 1/2/4) and framebuffer prefetch.
// Optional frame interrupt/counter outputs are enabled by defining VGA_FRAME_IRQ_EN.
module vga_scale_dis #(
  parameter int         H_FP            = 56,
  parameter int         H_SYNC          = 120,
  parameter int         H_BP            = 64,
  parameter int         H_ACT           = 800,
  parameter int         V_FP            = 37,
  parameter int         V_SYNC          = 6,
  parameter int         V_BP            = 23,
  parameter int         V_ACT           = 600,
  parameter bit         SYNC_POL        = 1'b1,
  parameter int         SRC_W           = 320,
  parameter int         SRC_H           = 200,
  parameter logic [11:0] BORDER_RGB     = 12'hfff,
  parameter int         X_WIDTH         = 11,
  parameter int         Y_WIDTH         = 11,
  parameter int         VMEM_ADDR_WIDTH = 20
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [1:0]       scale_sel,
  vga_scale_dis_if.master  vmem,
  output logic             hsync,
  output logic             vsync,
  output logic             de,
  output logic [3:0]       vga_r,
  output logic [3:0]       vga_g,
  output logic [3:0]       vga_b
`ifdef VGA_FRAME_IRQ_EN
  ,
  output logic             frame_irq,
  output logic [15:0]      frame_cnt
`endif
);

  localparam int H_TOT = H_FP + H_SYNC + H_BP + H_ACT;
  localparam int H_AST = H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_FP + V_SYNC + V_BP + V_ACT;
  localparam int V_AST = V_FP + V_SYNC + V_BP;

  // window extents, already clipped to the active region
  localparam int WIN_W1 = (SRC_W     < H_ACT) ? SRC_W     : H_ACT;
  localparam int WIN_W2 = (SRC_W * 2 < H_ACT) ? SRC_W * 2 : H_ACT;
  localparam int WIN_W4 = (SRC_W * 4 < H_ACT) ? SRC_W * 4 : H_ACT;
  localparam int WIN_H1 = (SRC_H     < V_ACT) ? SRC_H     : V_ACT;
  localparam int WIN_H2 = (SRC_H * 2 < V_ACT) ? SRC_H * 2 : V_ACT;
  localparam int WIN_H4 = (SRC_H * 4 < V_ACT) ? SRC_H * 4 : V_ACT;

  logic [X_WIDTH-1:0]         x_cnt, ax, win_w, src_x;
  logic [Y_WIDTH-1:0]         y_cnt, ay, win_h;
  logic [1:0]                 s_sh, s_max, sub_x, sub_y;
  logic [VMEM_ADDR_WIDTH-1:0] row_base, addr_hold, addr_out;
  logic                       frame_start, line_end, frame_last;
  logic                       hs0, vs0, de0, win0, win_last_col, win1;
  logic [11:0]                rgb;

  always_comb begin
    frame_start  = (x_cnt == '0) && (y_cnt == '0);
    line_end     = (x_cnt == X_WIDTH'(H_TOT - 1));
    frame_last   = line_end && (y_cnt == Y_WIDTH'(V_TOT - 1));
    hs0          = (x_cnt >= X_WIDTH'(H_FP)) && (x_cnt < X_WIDTH'(H_FP + H_SYNC));
    vs0          = (y_cnt >= Y_WIDTH'(V_FP)) && (y_cnt < Y_WIDTH'(V_FP + V_SYNC));
    de0          = (x_cnt >= X_WIDTH'(H_AST)) && (y_cnt >= Y_WIDTH'(V_AST));
    ax           = x_cnt - X_WIDTH'(H_AST);
    ay           = y_cnt - Y_WIDTH'(V_AST);
    case (s_sh)
      2'd0:    begin win_w = X_WIDTH'(WIN_W1); win_h = Y_WIDTH'(WIN_H1); s_max = 2'd0; end
      2'd1:    begin win_w = X_WIDTH'(WIN_W2); win_h = Y_WIDTH'(WIN_H2); s_max = 2'd1; end
      default: begin win_w = X_WIDTH'(WIN_W4); win_h = Y_WIDTH'(WIN_H4); s_max = 2'd3; end
    endcase
    win0         = de0 && (ax < win_w) && (ay < win_h);
    win_last_col = win0 && (ax == win_w - X_WIDTH'(1));
    addr_out     = win0 ? (row_base + VMEM_ADDR_WIDTH'(src_x)) : addr_hold;
  end

  assign vmem.vmem_r_addr = addr_out;
  assign vmem.vmem_r_en   = win0;

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      x_cnt <= '0;
      y_cnt <= '0;
    end else if (line_end) begin
      x_cnt <= '0;
      y_cnt <= (y_cnt == Y_WIDTH'(V_TOT - 1)) ? '0 : y_cnt + Y_WIDTH'(1);
    end else begin
      x_cnt <= x_cnt + X_WIDTH'(1);
    end
  end

  // scale is frozen for the whole frame; 3 is treated as 4x
  always_ff @(posedge pclk or posedge reset) begin
    if (reset)            s_sh <= 2'd0;
    else if (frame_start) s_sh <= (scale_sel == 2'd0) ? 2'd0 : (scale_sel == 2'd1) ? 2'd1 : 2'd2;
  end

  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      sub_x     <= '0;
      src_x     <= '0;
      sub_y     <= '0;
      row_base  <= '0;
      addr_hold <= '0;
    end else begin
      addr_hold <= addr_out;
      if (frame_start) begin
        sub_x    <= '0;
        src_x    <= '0;
        sub_y    <= '0;
        row_base <= '0;
      end else if (win_last_col) begin
        sub_x <= '0;
        src_x <= '0;
        if (sub_y == s_max) begin
          sub_y    <= '0;
          row_base <= row_base + VMEM_ADDR_WIDTH'(SRC_W);
        end else begin
          sub_y <= sub_y + 2'd1;
        end
      end else if (win0) begin
        if (sub_x == s_max) begin
          sub_x <= '0;
          src_x <= src_x + X_WIDTH'(1);
        end else begin
          sub_x <= sub_x + 2'd1;
        end
      end
    end
  end

  // stage 1 lines up with vga_data returned for the stage-0 address
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      hsync <= ~SYNC_POL;
      vsync <= ~SYNC_POL;
      de    <= 1'b0;
      win1  <= 1'b0;
    end else begin
      hsync <= hs0 ? SYNC_POL : ~SYNC_POL;
      vsync <= vs0 ? SYNC_POL : ~SYNC_POL;
      de    <= de0;
      win1  <= win0;
    end
  end

  always_comb begin
    rgb = 12'h000;
    if (win1)    rgb = vmem.vga_data;
    else if (de) rgb = BORDER_RGB;
  end

  assign vga_r = rgb[11:8];
  assign vga_g = rgb[7:4];
  assign vga_b = rgb[3:0];

`ifdef VGA_FRAME_IRQ_EN
  always_ff @(posedge pclk or posedge reset) begin
    if (reset) begin
      frame_irq <= 1'b0;
      frame_cnt <= 16'h0000;
    end else begin
      frame_irq <= frame_last;
      if (frame_irq) frame_cnt <= frame_cnt + 16'h0001;
    end
  end
`else
  logic unused_frame_last;
  assign unused_frame_last = frame_last;
`endif

endmodule
